// File: rtl/isqrt_rr_arbiter_if.sv
// Bundles the requester handshake and the isqrt issue/return path of
// isqrt_rr_arbiter into one interface; the arbiter takes the slave side.
interface isqrt_rr_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ*32-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    rsp_vld;
  logic [15:0]         rsp_y;
  logic                isqrt_x_vld;
  logic [31:0]         isqrt_x;
  logic                isqrt_y_vld;
  logic [15:0]         isqrt_y;
  logic                err_orphan;

  modport master (
    output req_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x, err_orphan
  );

  modport slave (
    input  req_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x, err_orphan
  );
endinterface

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one pipelined isqrt between N_REQ requesters; results are
// routed back via an in-flight ID FIFO. Define ISQRT_ARB_FIXED_PRIO_EN for fixed priority.
module isqrt_rr_arbiter #(
  parameter int N_REQ        = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input logic               clk,
  input logic               rst,
  isqrt_rr_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  fifo_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic             space;
  logic             issue;
  logic             pop;
  logic             orphan;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  head;
  logic [31:0]      sel_x;

  assign space  = (cnt < CNT_W'(MAX_INFLIGHT)) | bus.isqrt_y_vld;
  // Issue is blocked while rst is high so every output reads 0 during reset.
  assign issue  = !rst && space && (|bus.req_vld);
  assign pop    = bus.isqrt_y_vld && (cnt != '0);
  assign orphan = bus.isqrt_y_vld && (cnt == '0);
  assign head   = fifo_mem[rd_ptr];

`ifdef ISQRT_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_vld[ID_W'(i)]) winner = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] last_gnt;

  // Walk the ring starting just after the last grant; the first hit wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    logic            found;
    winner = '0;
    found  = 1'b0;
    cand   = last_gnt;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
      if (!found && bus.req_vld[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_gnt <= ID_W'(N_REQ - 1);
    else if (issue) last_gnt <= winner;
  end
`endif

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) sel_x = bus.req_x[32*i +: 32];
    end
  end

  always_comb begin
    bus.req_rdy     = '0;
    bus.isqrt_x_vld = 1'b0;
    bus.isqrt_x     = '0;
    bus.rsp_vld     = '0;
    bus.rsp_y       = '0;
    if (issue) begin
      bus.req_rdy[winner] = 1'b1;
      bus.isqrt_x_vld     = 1'b1;
      bus.isqrt_x         = sel_x;
    end
    if (pop) begin
      bus.rsp_vld[head] = 1'b1;
      bus.rsp_y         = bus.isqrt_y;
    end
  end

  assign bus.err_orphan = err_q;

  // Head is read combinationally before a same-cycle push overwrites the slot at full.
  always_ff @(posedge clk) begin
    if (issue) fifo_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({issue, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (orphan) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Directed bench for isqrt_rr_arbiter with a latency-4 isqrt stub and MAX_INFLIGHT=2.
module tb_isqrt_rr_arbiter;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_y = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  isqrt_rr_arbiter_if #(.N_REQ(3)) bus ();

  isqrt_rr_arbiter #(.N_REQ(3), .MAX_INFLIGHT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] isqrt_f(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  // isqrt stub: fixed latency L, shares rst; force_y injects a result with nothing behind it.
  logic [L-1:0] pv;
  logic [15:0]  pd [L];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else     pv <= {pv[L-2:0], bus.isqrt_x_vld};
  end
  always_ff @(posedge clk) begin
    pd[0] <= isqrt_f(bus.isqrt_x);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign bus.isqrt_y_vld = pv[L-1] | force_y;
  assign bus.isqrt_y     = pv[L-1] ? pd[L-1] : 16'hBEEF;

  typedef struct {
    logic [2:0]  vld;
    logic [95:0] x;
    logic [2:0]  rdy;
    logic [15:0] y;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] y;
  } exp_t;

  exp_t sb [$];
  int   gq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    sb.delete();
    gq.delete();
  endtask

  // One cycle of stimulus with scoreboard tracking of issues and responses.
  task automatic step(input logic [2:0] vld, input logic [95:0] xs,
                      output logic [2:0] rdy_s, output logic yv_s);
    exp_t e;
    int   id;
    @(negedge clk);
    bus.req_vld = vld;
    bus.req_x   = xs;
    #1;
    rdy_s = bus.req_rdy;
    yv_s  = bus.isqrt_y_vld;
    check("rdy_onehot_in_vld",
          32'(($onehot0(rdy_s) && ((rdy_s & ~vld) == 3'b000)) ? 1 : 0), 32'd1);
    check("x_vld_follows_rdy", 32'(bus.isqrt_x_vld), 32'(|rdy_s));
    if (bus.rsp_vld != 3'b000) begin
      if (sb.size() == 0) begin
        check("rsp_without_issue", 32'(bus.rsp_vld), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_vld), 32'(3'b001 << e.id));
        check("rsp_y", 32'(bus.rsp_y), 32'(e.y));
      end
    end
    if (rdy_s != 3'b000) begin
      id = 0;
      for (int i = 0; i < 3; i++) if (rdy_s[i]) id = i;
      check("isqrt_x", bus.isqrt_x, xs[32*id +: 32]);
      e.id = id;
      e.y  = isqrt_f(xs[32*id +: 32]);
      sb.push_back(e);
      gq.push_back(id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [8];
    logic [31:0] exp_x;
    logic [2:0]  rdy_s;
    logic        yv_s;
    int          issued;
    int          cyc;

    tbl[0] = '{3'b010, {32'd0, 32'd144, 32'd0}, 3'b010, 16'd12};
`ifdef ISQRT_ARB_FIXED_PRIO_EN
    tbl[1] = '{3'b111, {32'hFFFF_FFFF, 32'd4, 32'd1}, 3'b001, 16'd1};
`else
    tbl[1] = '{3'b111, {32'hFFFF_FFFF, 32'd4, 32'd1}, 3'b100, 16'd65535};
`endif
    tbl[2] = '{3'b111, {32'd17, 32'd16, 32'd15}, 3'b001, 16'd3};
`ifdef ISQRT_ARB_FIXED_PRIO_EN
    tbl[3] = '{3'b101, {32'd1000000, 32'd0, 32'd99}, 3'b001, 16'd9};
`else
    tbl[3] = '{3'b101, {32'd1000000, 32'd0, 32'd99}, 3'b100, 16'd1000};
`endif
    tbl[4] = '{3'b011, {32'd0, 32'd65536, 32'd0}, 3'b001, 16'd0};
    tbl[5] = '{3'b001, {32'd0, 32'd0, 32'd2147395600}, 3'b001, 16'd46340};
    tbl[6] = '{3'b000, {32'd5, 32'd6, 32'd7}, 3'b000, 16'd0};
    tbl[7] = '{3'b110, {32'd35, 32'd8, 32'd0}, 3'b010, 16'd2};

    // Reset state, including the grant being held off while rst is high.
    bus.req_vld = 3'b111;
    bus.req_x   = {32'd3, 32'd2, 32'd1};
    #3;
    check("rdy_during_reset", 32'(bus.req_rdy), 32'd0);
    check("x_vld_during_reset", 32'(bus.isqrt_x_vld), 32'd0);
    bus.req_vld = 3'b000;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("reset_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("reset_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("reset_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("reset_isqrt_x_vld", 32'(bus.isqrt_x_vld), 32'd0);
    check("reset_isqrt_x", bus.isqrt_x, 32'd0);
    check("reset_err_orphan", 32'(bus.err_orphan), 32'd0);

    // Table: single-cycle requests, each followed by its response L cycles later.
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus.req_vld = tbl[r].vld;
      bus.req_x   = tbl[r].x;
      #1;
      exp_x = '0;
      for (int i = 0; i < 3; i++) if (tbl[r].rdy[i]) exp_x = tbl[r].x[32*i +: 32];
      check("tbl_req_rdy", 32'(bus.req_rdy), 32'(tbl[r].rdy));
      check("tbl_isqrt_x_vld", 32'(bus.isqrt_x_vld), 32'(|tbl[r].rdy));
      check("tbl_isqrt_x", bus.isqrt_x, exp_x);
      @(negedge clk);
      bus.req_vld = 3'b000;
      repeat (L - 1) @(negedge clk);
      #1;
      check("tbl_rsp_vld", 32'(bus.rsp_vld), 32'(tbl[r].rdy));
      check("tbl_rsp_y", 32'(bus.rsp_y), 32'(tbl[r].y));
      @(negedge clk);
      #1;
      check("tbl_rsp_done", 32'(bus.rsp_vld), 32'd0);
    end

    // Continuous requests from all three into a 2-deep FIFO with latency 4.
    do_reset();
    for (int t = 0; t < 14; t++) begin
      step(3'b111, {32'd9, 32'd4, 32'd1}, rdy_s, yv_s);
      check("burst_issue_pattern", 32'(|rdy_s), 32'(((t % 4) < 2) ? 1 : 0));
      if (t >= 2) check("burst_issue_on_yvld", 32'(|rdy_s), 32'(yv_s));
      check("burst_inflight_le_2", 32'((sb.size() <= 2) ? 1 : 0), 32'd1);
    end
    for (int t = 0; t < 6; t++) step(3'b000, '0, rdy_s, yv_s);
    check("burst_grants", 32'(gq.size()), 32'd8);
    for (int k = 0; k < 6 && k < gq.size(); k++) begin
`ifdef ISQRT_ARB_FIXED_PRIO_EN
      check("burst_grant_order", 32'(gq[k]), 32'd0);
`else
      check("burst_grant_order", 32'(gq[k]), 32'(k % 3));
`endif
    end
    check("burst_all_answered", 32'(sb.size()), 32'd0);

    // Random requesters kept at full so push and pop coincide.
    issued = 0;
    cyc    = 0;
    while (issued < 20 && cyc < 200) begin
      step(3'($urandom_range(7, 1)), {$urandom, $urandom, $urandom}, rdy_s, yv_s);
      if (rdy_s != 3'b000) issued++;
      cyc++;
    end
    check("random_issue_budget", 32'(issued), 32'd20);
    for (int t = 0; t < 8; t++) step(3'b000, '0, rdy_s, yv_s);
    check("random_all_answered", 32'(sb.size()), 32'd0);

    // Orphan result with nothing in flight.
    @(negedge clk);
    force_y = 1'b1;
    #1;
    check("orphan_no_rsp", 32'(bus.rsp_vld), 32'd0);
    check("orphan_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("orphan_not_yet", 32'(bus.err_orphan), 32'd0);
    @(negedge clk);
    force_y = 1'b0;
    #1;
    check("orphan_set", 32'(bus.err_orphan), 32'd1);
    @(negedge clk);
    bus.req_vld = 3'b001;
    bus.req_x   = {32'd0, 32'd0, 32'd49};
    #1;
    check("post_orphan_rdy", 32'(bus.req_rdy), 32'd1);
    @(negedge clk);
    bus.req_vld = 3'b000;
    repeat (L - 1) @(negedge clk);
    #1;
    check("post_orphan_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    check("post_orphan_rsp_y", 32'(bus.rsp_y), 32'd7);
    check("orphan_sticky", 32'(bus.err_orphan), 32'd1);
    do_reset();
    #1;
    check("orphan_cleared_by_rst", 32'(bus.err_orphan), 32'd0);

    // Asynchronous reset with the FIFO full.
    @(negedge clk);
    bus.req_vld = 3'b001;
    bus.req_x   = {32'd0, 32'd36, 32'd25};
    @(negedge clk);
    bus.req_vld = 3'b010;
    @(negedge clk);
    bus.req_vld = 3'b111;
    bus.req_x   = {32'd64, 32'd36, 32'd81};
    #2 rst = 1'b1;
    #1;
    check("arst_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("arst_isqrt_x_vld", 32'(bus.isqrt_x_vld), 32'd0);
    check("arst_isqrt_x", bus.isqrt_x, 32'd0);
    check("arst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("arst_rsp_y", 32'(bus.rsp_y), 32'd0);
    check("arst_err_orphan", 32'(bus.err_orphan), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_next_grant", 32'(bus.req_rdy), 32'd1);
    for (int t = 1; t < L; t++) begin
      @(negedge clk);
      bus.req_vld = 3'b000;
      #1;
      check("arst_old_discarded", 32'(bus.rsp_vld), 32'd0);
      check("arst_no_orphan", 32'(bus.err_orphan), 32'd0);
    end
    @(negedge clk);
    #1;
    check("arst_new_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    check("arst_new_rsp_y", 32'(bus.rsp_y), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
